// File: rtl/pipe_rr_arbiter.sv
// pipe_rr_arbiter
//   Frame-aware round-robin arbiter. It shares one registered output stage
//   among NUM_REQS valid/ready sources. A source wins at the start of a frame
//   and keeps the grant until its last beat is accepted, so frames from
//   different sources never interleave. The output register is enable-gated
//   by load = !out_valid | out_ready. This gives 1-cycle latency and lets the
//   first beat of the next frame follow a last beat with no bubble.
//
// Parameters
//   NUM_REQS  number of requesters (>= 2)
//   DATAW     beat data width (>= 1)
//   SELW      grant index width, derived from NUM_REQS
//
// Ports
//   clk        clock, all logic on posedge
//   reset      synchronous active-high reset
//   req_valid  per-requester beat valid
//   req_data   requester i data at [i*DATAW +: DATAW]
//   req_last   per-requester last-of-frame flag
//   req_ready  per-requester accept (combinational)
//   out_valid  registered output beat valid
//   out_data   registered output data
//   out_last   registered last-of-frame flag
//   out_sel    index of the requester that sourced out_data
//   out_ready  downstream accept
module pipe_rr_arbiter #(
  parameter int  NUM_REQS = 4,
  parameter int  DATAW    = 8,
  localparam int SELW     = $clog2(NUM_REQS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       req_valid,
  input  logic [NUM_REQS*DATAW-1:0] req_data,
  input  logic [NUM_REQS-1:0]       req_last,
  output logic [NUM_REQS-1:0]       req_ready,
  output logic                      out_valid,
  output logic [DATAW-1:0]          out_data,
  output logic                      out_last,
  output logic [SELW-1:0]           out_sel,
  input  logic                      out_ready
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Index arithmetic modulo NUM_REQS. It also works when NUM_REQS is not a
  // power of two. ofs never exceeds NUM_REQS, so one subtraction is enough.
  function automatic logic [SELW-1:0] wrap_add(input logic [SELW-1:0] base,
                                               input int              ofs);
    int sum;
    sum = int'(base) + ofs;
    if (sum >= NUM_REQS) sum = sum - NUM_REQS;
    return SELW'(sum);
  endfunction

  state_t            state_q, state_d;
  logic [SELW-1:0]   ptr_q, ptr_d;
  logic [SELW-1:0]   grant_q, grant_d;

  logic              out_valid_q;
  logic [DATAW-1:0]  out_data_q;
  logic              out_last_q;
  logic [SELW-1:0]   out_sel_q;

  logic              rr_found;
  logic [SELW-1:0]   rr_idx;
  logic              locked;
  logic [SELW-1:0]   cur_grant;
  logic              cur_valid;
  logic              grant_ok;
  logic              load;
  logic              xfer;
  logic [DATAW-1:0]  beat_data;
  logic              beat_last;

  // Round-robin search. It starts at the pointer and wraps. The first valid
  // requester wins.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = ptr_q;
    for (int k = 0; k < NUM_REQS; k++) begin
      if (!rr_found && req_valid[wrap_add(ptr_q, k)]) begin
        rr_found = 1'b1;
        rr_idx   = wrap_add(ptr_q, k);
      end
    end
  end

  // In LOCKED, only the latched owner may transfer, even while its valid is
  // low. In IDLE, a grant exists only if somebody is requesting.
  assign locked    = (state_q == LOCKED);
  assign cur_grant = locked ? grant_q : rr_idx;
  assign cur_valid = locked ? req_valid[grant_q] : rr_found;
  assign grant_ok  = locked || rr_found;
  assign load      = !out_valid_q || out_ready;
  assign xfer      = load && cur_valid && !reset;

  always_comb begin
    req_ready = '0;
    beat_data = '0;
    beat_last = 1'b0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (SELW'(i) == cur_grant) begin
        req_ready[i] = load && grant_ok && !reset;
        beat_data    = req_data[i*DATAW +: DATAW];
        beat_last    = req_last[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    if (xfer) begin
      if (beat_last) begin
        state_d = IDLE;
        ptr_d   = wrap_add(cur_grant, 1);
      end else begin
        state_d = LOCKED;
        grant_d = cur_grant;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

  // ---- output stage: enable-gated register, holds while stalled ----
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
    end else if (load) begin
      out_valid_q <= xfer;
      if (xfer) begin
        out_data_q <= beat_data;
        out_last_q <= beat_last;
        out_sel_q  <= cur_grant;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_pipe_rr_arbiter.sv
// tb_pipe_rr_arbiter
//   Scoreboard bench for pipe_rr_arbiter (NUM_REQS=4, DATAW=8). Each source
//   has a queue of beats that the bench presents to the DUT. A reference
//   arbiter, stepped once per clock, predicts req_ready and the accepted
//   beats. It pushes the accepted beats to a scoreboard. The scoreboard is
//   popped whenever the DUT presents an output beat that is being taken.
//   Directed phases also compare the observed out_sel order to fixed lists.
module tb_pipe_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_last;
  logic [SW-1:0]   out_sel;
  logic            out_ready;

  pipe_rr_arbiter #(.NUM_REQS(N), .DATAW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic [3:0]    gap;
  } beat_t;

  typedef struct packed {
    logic [SW-1:0] sel;
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  beat_t src_q [N][$];
  int    gap_left [N];
  exp_t  sb [$];
  int    obs_sel [$];
  int    exp_seq [$];

  int n_chk  = 0;
  int n_fail = 0;

  // Reference arbiter state
  bit m_locked = 1'b0;
  int m_ptr    = 0;
  int m_grant  = 0;
  bit m_ov     = 1'b0;
  bit rst_seen = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] valid_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = (src_q[i].size() > 0) && (gap_left[i] == 0);
    return v;
  endfunction

  task automatic drive();
    req_valid = valid_vec();
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        req_data[i*DW +: DW] = src_q[i][0].data;
        req_last[i]          = src_q[i][0].last;
      end else begin
        req_data[i*DW +: DW] = '0;
        req_last[i]          = 1'b0;
      end
    end
  endtask

  task automatic push_beat(input int src, input logic [DW-1:0] d, input logic l, input int gap);
    beat_t b;
    b.data = d;
    b.last = l;
    b.gap  = 4'(gap);
    if (src_q[src].size() == 0) gap_left[src] = gap;
    src_q[src].push_back(b);
  endtask

  task automatic push_frame(input int src, input int len, input logic [DW-1:0] base, input int gap);
    for (int j = 0; j < len; j++)
      push_beat(src, base + DW'(j), (j == len - 1), (j == 0) ? gap : 0);
  endtask

  task automatic flush_sources();
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      gap_left[i] = 0;
    end
  endtask

  function automatic bit idle();
    bit e;
    e = (sb.size() == 0) && !m_ov;
    for (int i = 0; i < N; i++) if (src_q[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  // One clock: check at the negedge, advance the reference at the posedge,
  // then drive the next inputs 1 time unit later.
  task automatic tick();
    logic [N-1:0] vld;
    logic [N-1:0] exp_rdy;
    int           g;
    bit           load;
    bit           xfer;
    exp_t         e;
    @(negedge clk);
    vld  = valid_vec();
    load = !m_ov || out_ready;
    g    = -1;
    if (!reset) begin
      if (m_locked) g = m_grant;
      else begin
        for (int k = 0; k < N; k++) begin
          int c;
          c = (m_ptr + k) % N;
          if (g < 0 && vld[c]) g = c;
        end
      end
    end
    exp_rdy = '0;
    if (load && g >= 0) exp_rdy[g] = 1'b1;
    xfer = load && (g >= 0) && vld[g];

    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("out_valid", 32'(out_valid), 32'(m_ov));
    if (rst_seen) check("rst_out_sel", 32'(out_sel), 32'd0);
    if (out_valid && out_ready) begin
      obs_sel.push_back(int'(out_sel));
      if (sb.size() == 0) begin
        check("sb_occupancy", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check("out_sel",  32'(out_sel),  32'(e.sel));
        check("out_data", 32'(out_data), 32'(e.data));
        check("out_last", 32'(out_last), 32'(e.last));
      end
    end

    @(posedge clk);
    rst_seen = reset;
    if (reset) begin
      m_locked = 1'b0;
      m_ptr    = 0;
      m_ov     = 1'b0;
      sb.delete();
    end else begin
      if (load) m_ov = xfer;
      if (xfer) begin
        e.sel  = SW'(g);
        e.data = src_q[g][0].data;
        e.last = src_q[g][0].last;
        sb.push_back(e);
        if (e.last) begin
          m_locked = 1'b0;
          m_ptr    = (g + 1) % N;
        end else begin
          m_locked = 1'b1;
          m_grant  = g;
        end
        void'(src_q[g].pop_front());
        gap_left[g] = (src_q[g].size() > 0) ? int'(src_q[g][0].gap) : 0;
      end
    end
    for (int i = 0; i < N; i++)
      if (!(xfer && i == g) && src_q[i].size() > 0 && gap_left[i] > 0) gap_left[i]--;
    #1;
    drive();
  endtask

  task automatic drain(input int budget, input bit rnd);
    int n;
    n = 0;
    while (!idle() && n < budget) begin
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick();
      n++;
    end
    out_ready = 1'b1;
    check("drain_done", 32'(idle()), 32'd1);
  endtask

  task automatic check_seq(input string tag);
    check({tag, "_len"}, 32'(obs_sel.size()), 32'(exp_seq.size()));
    for (int i = 0; i < exp_seq.size() && i < obs_sel.size(); i++)
      check(tag, 32'(obs_sel[i]), 32'(exp_seq[i]));
    obs_sel.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    out_ready = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    for (int i = 0; i < N; i++) gap_left[i] = 0;

    // Reset held 3 cycles with every source valid, then 1-beat frames
    // rotate through all four sources.
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < N; i++) push_frame(i, 1, DW'(8'h10 * (i + 1) + r), 0);
    drive();
    repeat (3) tick();
    reset = 1'b0;
    obs_sel.delete();
    drain(200, 1'b0);
    exp_seq = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
    check_seq("rr_single_beat");

    // A 3-beat frame on req1 stays contiguous while req0 and req2 wait.
    push_frame(1, 3, 8'hA0, 0);
    push_frame(0, 1, 8'hB0, 1);
    push_frame(2, 1, 8'hC0, 1);
    drive();
    drain(200, 1'b0);
    exp_seq = '{1, 1, 1, 2, 0};
    check_seq("locked_frame");

    // Downstream stalls for 5 cycles while the output holds a beat.
    push_frame(0, 3, 8'h40, 0);
    push_frame(2, 3, 8'h60, 0);
    drive();
    repeat (3) tick();
    out_ready = 1'b0;
    repeat (5) tick();
    out_ready = 1'b1;
    drain(200, 1'b0);
    exp_seq = '{2, 2, 2, 0, 0, 0};
    check_seq("backpressure");

    // req3 drops valid for 4 cycles mid-frame. req0 must wait.
    push_beat(3, 8'h30, 1'b0, 0);
    push_beat(3, 8'h31, 1'b0, 0);
    push_beat(3, 8'h32, 1'b0, 4);
    push_beat(3, 8'h33, 1'b1, 0);
    push_frame(0, 1, 8'h50, 1);
    push_frame(0, 1, 8'h51, 0);
    drive();
    drain(200, 1'b0);
    exp_seq = '{3, 3, 3, 3, 0, 0};
    check_seq("owner_gap");

    // Reset lands after 2 of 4 beats. The frame is abandoned and the
    // pointer restarts at 0.
    push_frame(2, 4, 8'h70, 0);
    drive();
    repeat (2) tick();
    reset = 1'b1;
    repeat (2) tick();
    flush_sources();
    reset = 1'b0;
    obs_sel.delete();
    push_frame(3, 1, 8'h90, 0);
    push_frame(1, 1, 8'h80, 0);
    drive();
    drain(200, 1'b0);
    exp_seq = '{1, 3};
    check_seq("reset_midframe");

    // Mixed random frames, gaps and downstream stalls.
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < N; i++) begin
        int len;
        len = $urandom_range(1, 3);
        for (int j = 0; j < len; j++)
          push_beat(i, DW'($urandom_range(0, 255)), (j == len - 1),
                    (j == 0) ? $urandom_range(0, 2) : $urandom_range(0, 1));
      end
    end
    drive();
    drain(2000, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
